// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings
// and the bit-counter width helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit counter must index 0..W-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Operand/result bundle of serial_sub. The ovf wire and its modport
// entries exist only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_if #(parameter int W = 4);

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    // Requester side: drives operands, observes status and result.
    modport master (
        output start, a, b,
        input  busy, done, d, bout
`ifdef SERIAL_SUB_OVF_EN
        , input ovf
`endif
    );

    // Subtractor side.
    modport slave (
        input  start, a, b,
        output busy, done, d, bout
`ifdef SERIAL_SUB_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/serial_sub_fs.sv
// One-bit full subtractor y = a - b - bin, written as the databook gate
// netlist (xr2, ad2, or2, iv), one assign per gate.
module fs (
    output logic y,
    output logic bout,
    input  logic bin,
    input  logic a,
    input  logic b
);

    logic x_ab;    // xr2: a ^ b
    logic n_a;     // iv : ~a
    logic n_xab;   // iv : ~(a ^ b)
    logic g_brw;   // ad2: borrow generated (a=0, b=1)
    logic p_brw;   // ad2: borrow propagated (a==b, bin=1)

    assign x_ab  = a ^ b;
    assign y     = x_ab ^ bin;
    assign n_a   = ~a;
    assign n_xab = ~x_ab;
    assign g_brw = n_a & b;
    assign p_brw = n_xab & bin;
    assign bout  = g_brw | p_brw;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor d = a - b (mod 2^W), LSB first, one
// full-subtractor cell reused for W cycles with a borrow flop between bits.
// Optional feature macro: SERIAL_SUB_OVF_EN (adds signed-overflow output).
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    serial_sub_if.slave  bus
);

    localparam int CW = cnt_width(W);

    state_t         state_q, state_d;
    logic [W-1:0]   sa, sb, d_q;
    logic [CW-1:0]  cnt;
    logic           brw;
    logic           bout_q;
    logic           diff, bnext;
    logic           last_bit;
    logic           accept;

    // The single reused cell operates on the current LSBs.
    fs u_fs (
        .y    (diff),
        .bout (bnext),
        .bin  (brw),
        .a    (sa[0]),
        .b    (sb[0])
    );

    assign last_bit = (cnt == CW'(W - 1));
    assign accept   = (state_q == ST_IDLE) && bus.start;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit)  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: capture operands on accept, shift one bit per SHIFT cycle.
    // d is the shift register itself, so it shows partial results while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            d_q    <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            bout_q <= 1'b0;
        end else if (accept) begin
            sa  <= bus.a;
            sb  <= bus.b;
            brw <= 1'b0;
            cnt <= '0;
        end else if (state_q == ST_SHIFT) begin
            d_q <= {diff, d_q[W-1:1]};
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            brw <= bnext;
            cnt <= cnt + 1'b1;
            if (last_bit) bout_q <= bnext;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic am, bm, ovf_q;

    // Operand MSBs are shifted out early, so keep them for the overflow term,
    // which is resolved together with the result MSB on the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            am    <= 1'b0;
            bm    <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            am <= bus.a[W-1];
            bm <= bus.b[W-1];
        end else if (state_q == ST_SHIFT && last_bit) begin
            ovf_q <= (am ^ bm) & (am ^ diff);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy = (state_q == ST_SHIFT);
    assign bus.done = (state_q == ST_DONE);
    assign bus.d    = d_q;
    assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed cases plus random operands
// against an arithmetic reference (a - b mod 2^W, a < b, signed overflow).
module tb_serial_sub;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    serial_sub_if #(.W(W)) bus ();

    serial_sub #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation from IDLE; inputs applied at a negedge. Checks latency,
    // busy length, result and that done is a single pulse.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
        logic [W-1:0] exp_d;
        int busy_cnt, lat;
        logic got;
        exp_d = W'(av - bv);
        bus.a = av; bus.b = bv; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom);
        busy_cnt = 0; lat = -1; got = 1'b0;
        for (int i = 0; i < W + 6; i++) begin
            @(negedge clk);
            if (bus.done) begin got = 1'b1; lat = i; break; end
            if (bus.busy) busy_cnt++;
        end
        chk({tag, " done seen"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(W));
        chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(W));
        chk({tag, " d"}, 32'(bus.d), 32'(exp_d));
        chk({tag, " bout"}, 32'(bus.bout), 32'(av < bv));
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, " ovf"}, 32'(bus.ovf),
            32'((av[W-1] != bv[W-1]) && (exp_d[W-1] != av[W-1])));
`endif
        @(negedge clk);
        chk({tag, " done pulse width"}, 32'(bus.done), 32'd0);
        chk({tag, " d held"}, 32'(bus.d), 32'(exp_d));
    endtask

    initial begin
        int ndone;
        logic [W-1:0] ra, rb;

        rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
        #2;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset d", 32'(bus.d), 32'd0);
        chk("reset bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("reset ovf", 32'(bus.ovf), 32'd0);
`endif
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(4'd5, 4'd3, "5-3");
        do_op(4'd3, 4'd5, "3-5");
        do_op(4'd0, 4'd1, "0-1");
        do_op(4'd0, 4'd0, "0-0");
        do_op(4'hF, 4'hF, "F-F");
        do_op(4'hF, 4'h0, "F-0");

        // Start held high: results back to back every W+2 cycles.
        bus.a = 4'd9; bus.b = 4'd4; bus.start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 3 * (W + 2); i++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                chk("b2b phase", 32'(i % (W + 2)), 32'(W));
                chk("b2b d", 32'(bus.d), 32'd5);
                chk("b2b bout", 32'(bus.bout), 32'd0);
            end
        end
        bus.start = 1'b0;
        chk("b2b done count", 32'(ndone), 32'd3);
        @(negedge clk);
        @(negedge clk);

        // Operand change and start pulse while busy are ignored.
        bus.a = 4'd12; bus.b = 4'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 2 * (W + 2) + 2; i++) begin
            @(negedge clk);
            if (i == 1) begin bus.a = 4'd1; bus.b = 4'd2; bus.start = 1'b1; end
            if (i == 2) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                chk("ignore d", 32'(bus.d), 32'd9);
            end
        end
        chk("ignore done count", 32'(ndone), 32'd1);

        // Async reset mid-SHIFT.
        bus.a = 4'hF; bus.b = 4'h1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid-rst busy", 32'(bus.busy), 32'd0);
        chk("mid-rst done", 32'(bus.done), 32'd0);
        chk("mid-rst d", 32'(bus.d), 32'd0);
        chk("mid-rst bout", 32'(bus.bout), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("post-rst no done", 32'(ndone), 32'd0);
        do_op(4'd7, 4'd7, "7-7");

`ifdef SERIAL_SUB_OVF_EN
        do_op(4'h8, 4'h1, "ovf 8-1");
        do_op(4'h7, 4'hF, "ovf 7-F");
        do_op(4'h6, 4'h2, "ovf 6-2");
`endif

        for (int k = 0; k < 20; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_op(ra, rb, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
